// File: rtl/sodor5_seq_pkg.sv
// Shared constants, FSM encoding and the R-type word builder for the
// Sodor 5-stage instruction sequencer.
package sodor5_seq_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OPCODE_OP = 7'b0110011;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  // SUB/SRA variants only exist for funct3 0 and 5; everything else keeps funct7 = 0
  function automatic logic [31:0] build_rtype(input logic [31:0] l);
    logic [2:0] funct3;
    logic [6:0] funct7;
    funct3 = l[14:12];
    funct7 = (l[30] && (funct3 == 3'd0 || funct3 == 3'd5)) ? 7'b0100000 : 7'b0000000;
    return {funct7, l[24:20], l[19:15], funct3, l[11:7], OPCODE_OP};
  endfunction

endpackage

// File: rtl/sodor5_instr_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and the core (slave).
interface sodor5_instr_sequencer_if;

  logic [31:0] instr;
  logic        instr_valid;
  logic        req_ready;

  modport master (output instr, output instr_valid, input req_ready);
  modport slave  (input instr, input instr_valid, output req_ready);

endinterface

// File: rtl/sodor5_lfsr32.sv
// 32-bit Galois LFSR, right-shifting, advanced one step per load event.
module sodor5_lfsr32
  import sodor5_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_028F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [31:0] state
);

  // An all-zero state would lock up the LFSR, so a zero seed becomes 1
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  // State update: reload seed on reset, otherwise step when asked
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED_NZ;
    end else if (adv) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : 32'd0);
    end
  end

endmodule

// File: rtl/sodor5_instr_sequencer.sv
// Random RV32I R-type stream generator with RAW-hazard NOP insertion and a
// trailing NOP drain so the core can retire before the register-file compare.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | presenting real / hazard-NOP words until NUM_INSTR real ones are accepted
//   DRAIN | presenting DRAIN_NOPS trailing NOPs
//   DONE  | run finished, stream idle, start may begin a new run
module sodor5_instr_sequencer
  import sodor5_seq_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED     = 32'h0000_028F,
  parameter int unsigned NUM_INSTR     = 64,
  parameter int unsigned DRAIN_NOPS    = 5,
  parameter int unsigned HAZARD_WINDOW = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  sodor5_instr_sequencer_if.master    bus,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 issued_count
);

  localparam int          HW      = (HAZARD_WINDOW > 32'd4) ? 4 : int'(HAZARD_WINDOW);
  localparam logic [15:0] NUM_L   = 16'(NUM_INSTR);
  localparam logic [7:0]  DRAIN_L = 8'(DRAIN_NOPS);

  seq_state_t  state;
  logic [31:0] lfsr_state;
  logic [31:0] cand;
  logic [4:0]  hist [4];
  logic [15:0] loaded_count;
  logic [7:0]  drain_cnt;
  logic        cur_real;
  logic        hazard;
  logic        handshake;
  logic        start_ok;
  logic        run_real_load;

  assign handshake     = bus.instr_valid & bus.req_ready;
  assign start_ok      = start & ((state == IDLE) | (state == DONE));
  assign cand          = build_rtype(lfsr_state);
  assign run_real_load = (loaded_count != NUM_L) & ~hazard;

  sodor5_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (start_ok | handshake),
    .state (lfsr_state)
  );

  // RAW check: candidate source registers against the rds of recent loads
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < HW && hist[i] != 5'd0 &&
          (cand[19:15] == hist[i] || cand[24:20] == hist[i])) begin
        hazard = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered stream outputs, counters and rd history
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.instr       <= NOP_INSTR;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      issued_count    <= 16'd0;
      loaded_count    <= 16'd0;
      drain_cnt       <= 8'd0;
      cur_real        <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bus.instr_valid <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            issued_count    <= 16'd0;
            for (int i = 1; i < 4; i++) hist[i] <= 5'd0;
            if (NUM_L == 16'd0) begin
              state        <= DRAIN;
              bus.instr    <= NOP_INSTR;
              cur_real     <= 1'b0;
              loaded_count <= 16'd0;
              drain_cnt    <= DRAIN_L;
              hist[0]      <= 5'd0;
            end else begin
              // history is empty at run start, so the first word is never a hazard
              state        <= RUN;
              bus.instr    <= cand;
              cur_real     <= 1'b1;
              loaded_count <= 16'd1;
              hist[0]      <= cand[11:7];
            end
          end
        end
        RUN: begin
          if (handshake) begin
            if (cur_real && issued_count != 16'hFFFF) issued_count <= issued_count + 16'd1;
            for (int i = 3; i > 0; i--) hist[i] <= hist[i-1];
            if (cur_real && issued_count == NUM_L - 16'd1) begin
              state     <= DRAIN;
              bus.instr <= NOP_INSTR;
              cur_real  <= 1'b0;
              drain_cnt <= DRAIN_L;
              hist[0]   <= 5'd0;
            end else if (run_real_load) begin
              bus.instr    <= cand;
              cur_real     <= 1'b1;
              loaded_count <= loaded_count + 16'd1;
              hist[0]      <= cand[11:7];
            end else begin
              bus.instr <= NOP_INSTR;
              cur_real  <= 1'b0;
              hist[0]   <= 5'd0;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            drain_cnt <= drain_cnt - 8'd1;
            bus.instr <= NOP_INSTR;
            if (drain_cnt <= 8'd1) begin
              state           <= DONE;
              bus.instr_valid <= 1'b0;
              busy            <= 1'b0;
              done            <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sodor5_instr_sequencer.sv
// Directed bench: free-running and stalled streams, hazard NOP insertion,
// reset/start interactions, NUM_INSTR=0 and restart from DONE.
module tb_sodor5_instr_sequencer;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SEED_A = 32'h0000_028F;
  localparam logic [31:0] SEED_B = 32'h0001_0080;

  logic clk = 1'b0;
  logic reset;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  int tests = 0;
  int fails = 0;
  logic [31:0] l_run;

  always #5 clk = ~clk;

  sodor5_instr_sequencer_if bus_a ();
  sodor5_instr_sequencer_if bus_b ();
  sodor5_instr_sequencer_if bus_c ();

  sodor5_instr_sequencer #(.LFSR_SEED(SEED_A), .NUM_INSTR(4), .DRAIN_NOPS(5), .HAZARD_WINDOW(0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .issued_count(cnt_a));

  sodor5_instr_sequencer #(.LFSR_SEED(SEED_B), .NUM_INSTR(4), .DRAIN_NOPS(2), .HAZARD_WINDOW(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .issued_count(cnt_b));

  sodor5_instr_sequencer #(.LFSR_SEED(SEED_A), .NUM_INSTR(0), .DRAIN_NOPS(3), .HAZARD_WINDOW(0)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .bus(bus_c),
    .busy(busy_c), .done(done_c), .issued_count(cnt_c));

  function automatic logic [31:0] m_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [31:0] m_cand(input logic [31:0] l);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = l[14:12];
    f7 = (l[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
    return {f7, l[24:20], l[19:15], f3, l[11:7], 7'h33};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full NUM_INSTR=4 / DRAIN_NOPS=5 run on u_a starting from LFSR value l_in
  task automatic run_a(input bit stall, input int exp_cycles, input logic [31:0] l_in,
                       output logic [31:0] l_out);
    logic [31:0] l;
    logic [31:0] exp_w [9];
    int idx;
    int cyc;
    l = l_in;
    for (int k = 0; k < 9; k++) begin
      exp_w[k] = (k < 4) ? m_cand(l) : NOP;
      l = m_next(l);
    end
    l_out = m_next(l);
    start_a = 1'b1;
    bus_a.req_ready = 1'b0;
    tick();
    start_a = 1'b0;
    idx = 0;
    cyc = 1;
    while (idx < 9 && cyc < 60) begin
      bus_a.req_ready = stall ? (cyc % 2 == 0) : 1'b1;
      chk_b("a_valid", bus_a.instr_valid, 1'b1);
      chk_b("a_busy", busy_a, 1'b1);
      chk("a_instr", bus_a.instr, exp_w[idx]);
      chk("a_count", {16'd0, cnt_a}, (idx < 4) ? idx : 4);
      tick();
      if (bus_a.req_ready) idx++;
      cyc++;
    end
    bus_a.req_ready = 1'b0;
    chk("a_run_cycles", cyc, exp_cycles);
    chk_b("a_done", done_a, 1'b1);
    chk_b("a_busy_end", busy_a, 1'b0);
    chk_b("a_valid_end", bus_a.instr_valid, 1'b0);
    chk("a_instr_end", bus_a.instr, NOP);
    chk("a_count_end", {16'd0, cnt_a}, 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_b [7];
    logic [15:0] cnt_exp_b [7];
    exp_b     = '{32'h0000_00B3 | 32'h0001_0000, NOP, 32'h0000_4033, 32'h0000_2033,
                  32'h0000_1033, NOP, NOP};
    cnt_exp_b = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4};

    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bus_a.req_ready = 1'b0; bus_b.req_ready = 1'b0; bus_c.req_ready = 1'b0;
    repeat (3) tick();
    chk("rst_instr", bus_a.instr, NOP);
    chk_b("rst_valid", bus_a.instr_valid, 1'b0);
    chk_b("rst_busy", busy_a, 1'b0);
    chk_b("rst_done", done_a, 1'b0);
    chk("rst_count", {16'd0, cnt_a}, 32'd0);
    chk_b("rst_valid_b", bus_b.instr_valid, 1'b0);
    reset = 1'b0;
    tick();

    // free-running stream
    run_a(1'b0, 10, SEED_A, l_run);

    // restart from DONE: count clears, LFSR continues, then reset mid-RUN
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_count", {16'd0, cnt_a}, 32'd0);
    chk_b("restart_busy", busy_a, 1'b1);
    chk("restart_w0", bus_a.instr, m_cand(l_run));
    bus_a.req_ready = 1'b1;
    tick();
    chk("restart_w1", bus_a.instr, m_cand(m_next(l_run)));
    chk("restart_cnt1", {16'd0, cnt_a}, 32'd1);
    tick();
    chk("restart_w2", bus_a.instr, m_cand(m_next(m_next(l_run))));
    chk("restart_cnt2", {16'd0, cnt_a}, 32'd2);
    bus_a.req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_instr", bus_a.instr, NOP);
    chk_b("midrst_valid", bus_a.instr_valid, 1'b0);
    chk_b("midrst_busy", busy_a, 1'b0);
    chk("midrst_count", {16'd0, cnt_a}, 32'd0);

    // start together with reset is overridden
    reset = 1'b1;
    start_a = 1'b1;
    tick();
    reset = 1'b0;
    start_a = 1'b0;
    chk_b("rst_start_busy", busy_a, 1'b0);
    chk_b("rst_start_valid", bus_a.instr_valid, 1'b0);
    tick();
    chk_b("rst_start_busy2", busy_a, 1'b0);
    chk_b("rst_start_done2", done_a, 1'b0);

    // stalled stream: LFSR back at seed, same words, longer run
    run_a(1'b1, 19, SEED_A, l_run);

    // hazard NOP insertion; a start pulse mid-RUN must be ignored
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus_b.req_ready = 1'b1;
      chk("b_instr", bus_b.instr, exp_b[k]);
      chk_b("b_valid", bus_b.instr_valid, 1'b1);
      if (k == 2) start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("b_count", {16'd0, cnt_b}, {16'd0, cnt_exp_b[k]});
    end
    bus_b.req_ready = 1'b0;
    chk_b("b_done", done_b, 1'b1);
    chk_b("b_valid_end", bus_b.instr_valid, 1'b0);

    // NUM_INSTR=0: straight to drain
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk_b("c_busy", busy_c, 1'b1);
    chk_b("c_valid", bus_c.instr_valid, 1'b1);
    chk("c_instr", bus_c.instr, NOP);
    bus_c.req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_b("c_done_early", done_c, 1'b0);
      tick();
    end
    bus_c.req_ready = 1'b0;
    chk_b("c_done", done_c, 1'b1);
    chk("c_count", {16'd0, cnt_c}, 32'd0);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk_b("c_restart_busy", busy_c, 1'b1);
    chk_b("c_restart_done", done_c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
